// File: rtl/mul_table_gen.sv
`timescale 1ns/1ps
// mul_table_gen
// Walks every operand pair {a, b} in order. Each product is formed by a
// W-step shift-add multiplier and then streamed out on a valid/ready write
// port that feeds the table memory.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   level, sampled only in IDLE; launches a full table pass
//   wr_ready in   memory accepts the presented write this cycle
//   we       out  write valid (WRITE state only)
//   waddr    out  {a, b}, a in the upper W bits; holds outside WRITE
//   wdata    out  a*b; holds outside WRITE
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse after the last entry is accepted
module mul_table_gen #(
    parameter int W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          wr_ready,
    output logic          we,
    output logic [2*W-1:0] waddr,
    output logic [2*W-1:0] wdata,
    output logic          busy,
    output logic          done
);
    localparam int AW = 2 * W;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MUL,
        S_WRITE,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_idx;
    logic [AW-1:0]   r_acc;
    logic [AW-1:0]   r_mcand;
    logic [W-1:0]    r_mplier;
    logic [CW-1:0]   r_cnt;
    logic [AW-1:0]   r_waddr;
    logic [AW-1:0]   r_wdata;
    logic [AW-1:0]   w_acc_nxt;

    // Partial-product add for the current multiplier bit.
    assign w_acc_nxt = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
            r_waddr  <= '0;
            r_wdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_acc    <= '0;
                    r_mcand  <= {{W{1'b0}}, r_idx[AW-1:W]};
                    r_mplier <= r_idx[W-1:0];
                    r_cnt    <= '0;
                    r_state  <= S_MUL;
                end
                S_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    // Last step: latch the write beat from the final sum so the
                    // output registers are ready the cycle WRITE is entered.
                    if (r_cnt == CW'(W - 1)) begin
                        r_waddr <= r_idx;
                        r_wdata <= w_acc_nxt;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (wr_ready) begin
                        if (r_idx == {AW{1'b1}}) begin
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + AW'(1);
                            r_state <= S_LOAD;
                        end
                    end
                end
                S_DONE: r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs come straight from state/registers; no input-to-output path.
    assign we    = (r_state == S_WRITE);
    assign waddr = r_waddr;
    assign wdata = r_wdata;
    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);

endmodule
